// File: rtl/calculator_pkg.sv
// Shared calculator constants plus the result_reader state encoding.
// Address and data widths here are common to the controller and the reader.
package calculator_pkg;

  localparam int ADDR_W        = 8;
  localparam int DATA_W        = 32;
  localparam int MEM_WORD_SIZE = 2 * DATA_W;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_CAP  = 3'd2,
    S_OUT  = 3'd3,
    S_DONE = 3'd4
  } result_reader_state_t;

  // An inclusive range is legal only when it does not run backwards.
  function automatic logic range_ok(input logic [ADDR_W-1:0] first_addr,
                                    input logic [ADDR_W-1:0] last_addr);
    return last_addr >= first_addr;
  endfunction

endpackage

// File: rtl/result_reader_if.sv
// Bundles the drain command, SRAM read port and result stream of result_reader.
// Stream rule: a word transfers on a rising edge where res_valid_o && res_ready_i; once
// res_valid_o rises, it and res_data_o/res_last_o hold until that transfer (or reset).
interface result_reader_if;
  import calculator_pkg::*;

  logic                     start_i;
  logic [ADDR_W-1:0]        rd_start_addr_i;
  logic [ADDR_W-1:0]        rd_end_addr_i;
  logic                     mem_read_o;
  logic [ADDR_W-1:0]        mem_addr_o;
  logic [DATA_W-1:0]        mem_rdata_a_i;
  logic [DATA_W-1:0]        mem_rdata_b_i;
  logic [MEM_WORD_SIZE-1:0] res_data_o;
  logic                     res_valid_o;
  logic                     res_ready_i;
  logic                     res_last_o;
  logic                     busy_o;
  logic                     done_o;
  logic                     err_o;

  modport master (
    input  start_i, rd_start_addr_i, rd_end_addr_i,
    input  mem_rdata_a_i, mem_rdata_b_i, res_ready_i,
    output mem_read_o, mem_addr_o,
    output res_data_o, res_valid_o, res_last_o,
    output busy_o, done_o, err_o
  );

  modport slave (
    output start_i, rd_start_addr_i, rd_end_addr_i,
    output mem_rdata_a_i, mem_rdata_b_i, res_ready_i,
    input  mem_read_o, mem_addr_o,
    input  res_data_o, res_valid_o, res_last_o,
    input  busy_o, done_o, err_o
  );

endinterface

// File: rtl/result_reader.sv
// Drains an inclusive SRAM address range, joining bank A (upper) and bank B (lower)
// into one 64-bit word per address and offering it on a valid/ready stream.
module result_reader
  import calculator_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  result_reader_if.master      bus,
  output result_reader_state_t state_o
);

  result_reader_state_t     state_q, state_d;
  logic [ADDR_W-1:0]        cur_addr_q;
  logic [ADDR_W-1:0]        end_addr_q;
  logic [MEM_WORD_SIZE-1:0] res_data_q;
  logic                     res_last_q;
  logic                     err_q;

  logic start_acc;
  logic range_good;
  logic handshake;

  assign start_acc  = (state_q == S_IDLE) && bus.start_i;
  assign range_good = range_ok(bus.rd_start_addr_i, bus.rd_end_addr_i);
  assign handshake  = (state_q == S_OUT) && bus.res_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) state_d = range_good ? S_REQ : S_DONE;
      end
      S_REQ:  state_d = S_CAP;
      S_CAP:  state_d = S_OUT;
      S_OUT: begin
        if (bus.res_ready_i) state_d = res_last_q ? S_DONE : S_REQ;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The last word never increments, so a range ending at the top address cannot wrap.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cur_addr_q <= '0;
    end else if (start_acc && range_good) begin
      cur_addr_q <= bus.rd_start_addr_i;
    end else if (handshake && !res_last_q) begin
      cur_addr_q <= cur_addr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i)         end_addr_q <= '0;
    else if (start_acc) end_addr_q <= bus.rd_end_addr_i;
  end

  // SRAM data is valid in S_CAP, the cycle after the read was issued.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      res_data_q <= '0;
      res_last_q <= 1'b0;
    end else if (state_q == S_CAP) begin
      res_data_q <= {bus.mem_rdata_a_i, bus.mem_rdata_b_i};
      res_last_q <= (cur_addr_q == end_addr_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i)         err_q <= 1'b0;
    else if (start_acc) err_q <= !range_good;
  end

  assign bus.mem_read_o  = (state_q != S_REQ);
  assign bus.mem_addr_o  = cur_addr_q;
  assign bus.res_data_o  = res_data_q;
  assign bus.res_valid_o = (state_q == S_OUT);
  assign bus.res_last_o  = res_last_q;
  assign bus.busy_o      = (state_q != S_IDLE);
  assign bus.done_o      = (state_q == S_DONE);
  assign bus.err_o       = err_q;
  assign state_o         = state_q;

endmodule

// File: doc/result_reader.md
# result_reader

Drains computed results out of the calculator's two result SRAMs and presents them as a 64-bit valid/ready stream. The controller stores each sum upper-half in SRAM A and lower-half in SRAM B at one address; this block reads an address range back and reassembles each {A,B} pair into one result word. It sits beside the controller on the SRAM read port, and the top level grants it the port only after the controller has finished.

## Interface
Parameters and constants come from `calculator_pkg`:
- ADDR_W, package value; SRAM address width
- DATA_W, package value (32); per-bank word width
- MEM_WORD_SIZE, package value (64); result word width, equal to 2*DATA_W

Ports:
- clk_i  in  1  single clock; all logic is on its rising edge
- rst_i  in  1  synchronous, active-low reset; sampled on clk_i
- start_i  in  1  one-cycle pulse that launches a drain; honoured in S_IDLE only
- rd_start_addr_i  in  ADDR_W  first address; sampled when start_i is accepted
- rd_end_addr_i  in  ADDR_W  last address, inclusive; sampled when start_i is accepted
- mem_read_o  out  1  SRAM read enable, active-low (0 = read)
- mem_addr_o  out  ADDR_W  SRAM read address, shared by both banks
- mem_rdata_a_i  in  DATA_W  SRAM A read data; valid one cycle after mem_read_o=0
- mem_rdata_b_i  in  DATA_W  SRAM B read data; same timing as SRAM A
- res_data_o  out  MEM_WORD_SIZE  result word, {mem_rdata_a_i, mem_rdata_b_i}
- res_valid_o  out  1  result word is valid
- res_ready_i  in  1  consumer accepts the word
- res_last_o  out  1  current word is from rd_end_addr; qualified by res_valid_o
- busy_o  out  1  high in every state except S_IDLE
- done_o  out  1  one-cycle pulse when a drain completes or is rejected
- err_o  out  1  sticky range error; cleared by the next accepted start_i

## Operation
States: S_IDLE, S_REQ, S_CAP, S_OUT, S_DONE.
- S_IDLE: on start_i, latch the start and end addresses into internal registers and clear err_o.
  - If end < start (unsigned), set err_o and go to S_DONE. No SRAM read is issued.
  - Otherwise load cur_addr with the start address and go to S_REQ.
- S_REQ: drive mem_read_o=0 and mem_addr_o=cur_addr, then go to S_CAP.
- S_CAP: register {mem_rdata_a_i, mem_rdata_b_i} into res_data_o, set res_last_o=(cur_addr==end), then go to S_OUT.
- S_OUT: hold res_valid_o=1. res_data_o and res_last_o stay stable until res_valid_o && res_ready_i.
  - On handshake with last=1, go to S_DONE.
  - On handshake with last=0, increment cur_addr and go to S_REQ.
- S_DONE: done_o=1 for this cycle only, then go to S_IDLE.
- The last-word test compares before incrementing, so end = 2^ADDR_W-1 terminates correctly and the address never wraps.
- start_i in any state other than S_IDLE is ignored, including in S_DONE.
- The block never writes the SRAMs.

## Timing
- Reset values: mem_read_o=1, mem_addr_o=0, res_data_o=0, res_valid_o=0, res_last_o=0, busy_o=0, done_o=0, err_o=0. The state is S_IDLE.
- Reset mid-drain: the state returns to S_IDLE at that edge. Any word in flight is dropped and no done_o is produced.
- start_i accepted at edge N:
  - mem_read_o=0 during cycle N+1.
  - res_valid_o=1 from cycle N+3.
- Minimum period is 3 cycles per word when res_ready_i is held high.
- After the final handshake at edge M, done_o=1 during cycle M+1.
- A rejected range (end < start) produces done_o and err_o during the cycle after start_i.
- mem_read_o is 0 only in S_REQ. In every other cycle mem_addr_o holds its last value.
- res_valid_o is never deasserted without a handshake, except by reset.

## Structure
- Put the state_t enum (result_reader_state_t) in `calculator_pkg`, next to ADDR_W, DATA_W and MEM_WORD_SIZE.
- Keep the design flat: one state register, a next-state always_comb, and separate always_ff blocks for cur_addr, the latched end address, the output register and err_o.
- No sub-module.

## Test plan
- Single word: start=end=5; A[5]=32'h0000_0001, B[5]=32'hFFFF_FFFF; ready held high. Required: one word 64'h0000_0001_FFFF_FFFF with last=1, read issued 1 cycle after start, valid 3 cycles after start, done_o pulse one cycle after the handshake.
- Range 0..3: ready held high. Required: four words in address order, exactly 3 cycles apart; last=1 only on the fourth; exactly 4 cycles with mem_read_o=0.
- Backpressure on 10..11: ready low for 7 cycles on the first word. Required: data and last stable throughout, no new read issued, second word read only after the handshake.
- Bad range: start=8, end=3. Required: err_o=1, done_o one cycle after start, no read issued, no valid. The next legal start clears err_o.
- Top-of-memory and reset: range 2^ADDR_W-2..2^ADDR_W-1 ends correctly with no address wrap. Pulling rst_i low in S_OUT, then pulsing start_i while busy, leaves all outputs at their reset values and ignores start_i.
